rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: three per-requester FIFOs of {waddr, wdata} drained
// round-robin into a single registered register-file write port.
module rf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [2:0]  in_valid,
    output logic [2:0]  in_ready,
    input  logic [14:0] in_waddr,
    input  logic [95:0] in_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  grant_id,
    output logic        pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    waddr_mem_q [3][DEPTH];
    logic [4:0]    waddr_mem_d [3][DEPTH];
    logic [31:0]   wdata_mem_q [3][DEPTH];
    logic [31:0]   wdata_mem_d [3][DEPTH];
    logic [PW-1:0] wr_ptr_q [3];
    logic [PW-1:0] wr_ptr_d [3];
    logic [PW-1:0] rd_ptr_q [3];
    logic [PW-1:0] rd_ptr_d [3];
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic [1:0]    grant_id_q, grant_id_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;

    logic [2:0]    empty;
    logic [2:0]    full;
    logic [2:0]    push;
    logic [2:0]    pop;
    logic          found;
    logic [1:0]    win;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            empty[i] = (cnt_q[i] == CW'(0));
            full[i]  = (cnt_q[i] == CW'(DEPTH));
        end
    end

    // Ready is purely a function of stored occupancy so producers never see
    // a combinational path from their own valid or from this cycle's grant.
    assign in_ready = ~full & {3{~rst}};
    assign pending  = |(~empty);

    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= 3) idx = idx - 3;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
    end

    always_comb begin
        waddr_mem_d = waddr_mem_q;
        wdata_mem_d = wdata_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        push        = 3'b000;
        pop         = 3'b000;

        for (int i = 0; i < 3; i++) begin
            // Writes to r0 complete the handshake but are dropped here.
            push[i] = in_valid[i] && in_ready[i] && (in_waddr[5*i +: 5] != 5'd0);
            pop[i]  = found && (win == 2'(i));
            if (push[i]) begin
                waddr_mem_d[i][wr_ptr_q[i]] = in_waddr[5*i +: 5];
                wdata_mem_d[i][wr_ptr_q[i]] = in_wdata[32*i +: 32];
                wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            end
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end

        if (found) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = waddr_mem_q[win][rd_ptr_q[win]];
            rf_wdata_d = wdata_mem_q[win][rd_ptr_q[win]];
            grant_id_d = win;
            rr_ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end

        if (flush) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end
            rf_we_d    = 1'b0;
            rf_waddr_d = rf_waddr_q;
            rf_wdata_d = rf_wdata_q;
            grant_id_d = grant_id_q;
            rr_ptr_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    waddr_mem_q[i][j] <= '0;
                    wdata_mem_q[i][j] <= '0;
                end
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            waddr_mem_q <= waddr_mem_d;
            wdata_mem_q <= wdata_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: single pushes, round-robin triples,
// r0 drops, flush, sustained backpressure and mid-cycle reset.
module tb_rf_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        flush;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [14:0] in_waddr;
    logic [95:0] in_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  grant_id;
    logic        pending;

    int n_cmp = 0;
    int n_bad = 0;

    rf_wb_arbiter #(.DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_waddr (in_waddr),
        .in_wdata (in_wdata),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .grant_id (grant_id),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq [3];
    int popcnt [3];
    int total_pops;
    logic [2:0] ready_pre;
    int g;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = '0; in_waddr = '0; in_wdata = '0;
        #2;
        chk_eq("rst_we", rf_we, 0);
        chk_eq("rst_waddr", rf_waddr, 0);
        chk_eq("rst_wdata", rf_wdata, 0);
        chk_eq("rst_gid", grant_id, 0);
        chk_eq("rst_pend", pending, 0);
        chk_eq("rst_ready", in_ready, 3'b000);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_eq("post_rst_ready", in_ready, 3'b111);

        // single push, requester 0
        in_valid = 3'b001; in_waddr[4:0] = 5'd5; in_wdata[31:0] = 32'hDEADBEEF;
        tick();
        chk_eq("single_we_lat", rf_we, 0);
        chk_eq("single_pend", pending, 1);
        in_valid = '0;
        tick();
        chk_eq("single_we", rf_we, 1);
        chk_eq("single_waddr", rf_waddr, 5);
        chk_eq("single_wdata", rf_wdata, 32'hDEADBEEF);
        chk_eq("single_gid", grant_id, 0);
        chk_eq("single_pend_after", pending, 0);
        tick();
        chk_eq("single_we_end", rf_we, 0);
        chk_eq("single_waddr_hold", rf_waddr, 5);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_eq("flush_we", rf_we, 0);

        // two back-to-back triples drain 1,2,3 each time
        for (int rep = 0; rep < 2; rep++) begin
            in_valid = 3'b111;
            in_waddr = {5'd3, 5'd2, 5'd1};
            in_wdata = {32'h33, 32'h22, 32'h11};
            tick();
            in_valid = '0;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk_eq("tri_we", rf_we, 1);
                chk_eq("tri_waddr", rf_waddr, j + 1);
                chk_eq("tri_wdata", rf_wdata, (j + 1) * 32'h11);
                chk_eq("tri_gid", grant_id, j);
            end
            tick();
            chk_eq("tri_idle", rf_we, 0);
            chk_eq("tri_pend", pending, 0);
        end

        // write to r0 is accepted and dropped
        in_valid = 3'b010; in_waddr = '0; in_wdata = '0; in_wdata[63:32] = 32'h12345678;
        chk_eq("r0_ready", in_ready[1], 1);
        tick();
        in_valid = '0;
        chk_eq("r0_pend", pending, 0);
        chk_eq("r0_we0", rf_we, 0);
        tick();
        chk_eq("r0_we1", rf_we, 0);

        // flush with entries queued and rr_ptr advanced
        in_valid = 3'b111; in_waddr = {5'd9, 5'd8, 5'd7}; in_wdata = {32'h9, 32'h8, 32'h7};
        tick();
        in_valid = 3'b001; in_waddr = '0; in_waddr[4:0] = 5'd11;
        tick();
        chk_eq("fl_pre_waddr", rf_waddr, 7);
        chk_eq("fl_pre_pend", pending, 1);
        flush = 1'b1; in_valid = 3'b100; in_waddr = '0; in_waddr[14:10] = 5'd10;
        tick();
        flush = 1'b0; in_valid = '0;
        chk_eq("fl_we", rf_we, 0);
        chk_eq("fl_pend", pending, 0);
        chk_eq("fl_ready", in_ready, 3'b111);
        in_valid = 3'b101; in_waddr = '0; in_waddr[4:0] = 5'd12; in_waddr[14:10] = 5'd13;
        tick();
        in_valid = '0;
        tick();
        chk_eq("fl_rr0_waddr", rf_waddr, 12);
        chk_eq("fl_rr0_gid", grant_id, 0);
        tick();
        chk_eq("fl_rr1_waddr", rf_waddr, 13);
        chk_eq("fl_rr1_gid", grant_id, 2);
        tick();
        chk_eq("fl_done_we", rf_we, 0);
        chk_eq("fl_done_pend", pending, 0);

        // sustained valid on all three for 20 cycles
        for (int i = 0; i < 3; i++) begin seq[i] = 0; popcnt[i] = 0; end
        total_pops = 0;
        in_waddr = {5'd3, 5'd2, 5'd1};
        for (int k = 0; k < 20; k++) begin
            in_valid = 3'b111;
            for (int i = 0; i < 3; i++) in_wdata[32*i +: 32] = 32'hA000_0000 | (i << 16) | seq[i];
            ready_pre = in_ready;
            tick();
            for (int i = 0; i < 3; i++) if (ready_pre[i]) seq[i]++;
            if (k == 0) begin
                chk_eq("sus_we0", rf_we, 0);
                chk_eq("sus_ready0", in_ready, 3'b111);
            end else begin
                g = (k - 1) % 3;
                chk_eq("sus_we", rf_we, 1);
                chk_eq("sus_gid", grant_id, g);
                chk_eq("sus_waddr", rf_waddr, g + 1);
                chk_eq("sus_wdata", rf_wdata, 32'hA000_0000 | (g << 16) | popcnt[g]);
                chk_eq("sus_ready", in_ready, 3'b001 << g);
                popcnt[g]++;
                total_pops++;
            end
        end
        in_valid = '0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (rf_we) begin
                g = grant_id;
                chk_eq("drain_wdata", rf_wdata, 32'hA000_0000 | (g << 16) | popcnt[g]);
                popcnt[g]++;
                total_pops++;
            end
        end
        chk_eq("sus_total", total_pops, 24);
        for (int i = 0; i < 3; i++) chk_eq("sus_per_req", popcnt[i], 8);
        chk_eq("sus_pend", pending, 0);

        // asynchronous reset mid-stream
        in_valid = 3'b111; in_waddr = {5'd3, 5'd2, 5'd1}; in_wdata = {32'h3, 32'h2, 32'h1};
        tick();
        in_valid = '0;
        tick();
        chk_eq("ar_pre_we", rf_we, 1);
        #2 rst = 1'b1;
        #1;
        chk_eq("ar_we", rf_we, 0);
        chk_eq("ar_ready", in_ready, 3'b000);
        chk_eq("ar_pend", pending, 0);
        chk_eq("ar_waddr", rf_waddr, 0);
        #3 rst = 1'b0;
        #1 chk_eq("ar_rel_ready", in_ready, 3'b111);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk_eq("ar_no_stale", rf_we, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
